// File: rtl/apb_scoreboard.sv
// Captures APB writes to one device into a result table and, on start, compares it entry by entry
// against a loadable expected table. Optional macro APB_SCOREBOARD_MASK_EN adds a per-entry compare mask.
module apb_scoreboard #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEV_W     = 4,
  parameter int DEVICE_ID = 0,
  parameter int DEPTH     = 8,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic              apb_write,
  input  logic [ADDR_W-1:0] apb_addr,
  input  logic [DATA_W-1:0] apb_data,
  input  logic [DEV_W-1:0]  apb_device,
  input  logic              exp_load,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic              err_valid
`ifdef APB_SCOREBOARD_MASK_EN
  ,
  input  logic [DATA_W-1:0] exp_mask
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   DEPTH_I = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] got     [DEPTH];
  logic [DATA_W-1:0] exp_tab [DEPTH];
  logic [DEPTH-1:0]  wvalid;
  logic [IDX_W-1:0]  idx;
  logic              capture_en, load_en, mismatch;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] data_diff;
  logic [CNT_W-1:0]  err_cnt_nxt;

  // Tables only change in IDLE so a pass always sees a frozen snapshot.
  assign capture_en = ready && apb_write && (apb_device == DEV_W'(DEVICE_ID))
                      && ({1'b0, apb_addr} < DEPTH_A) && (state == IDLE);
  assign cap_idx    = apb_addr[IDX_W-1:0];
  assign load_en    = exp_load && ({1'b0, exp_idx} < DEPTH_I) && (state == IDLE);

`ifdef APB_SCOREBOARD_MASK_EN
  logic [DATA_W-1:0] mask_tab [DEPTH];

  always_ff @(posedge clk) begin
    if (load_en) mask_tab[exp_idx] <= exp_mask;
  end

  assign data_diff = (got[idx] ^ exp_tab[idx]) & mask_tab[idx];
`else
  assign data_diff = got[idx] ^ exp_tab[idx];
`endif

  // A never-written entry is a mismatch regardless of data or mask.
  assign mismatch    = !wvalid[idx] || (data_diff != '0);
  assign err_cnt_nxt = err_count + CNT_W'(mismatch);

  always_ff @(posedge clk) begin
    if (capture_en) got[cap_idx] <= apb_data;
    if (load_en)    exp_tab[exp_idx] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wvalid        <= '0;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      err_valid     <= 1'b0;
      pass          <= 1'b0;
    end else begin
      if (capture_en) wvalid[cap_idx] <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            idx           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            err_valid     <= 1'b0;
            pass          <= 1'b0;
          end
        end
        CHECK: begin
          err_count <= err_cnt_nxt;
          if (mismatch && !err_valid) begin
            first_err_idx <= idx;
            err_valid     <= 1'b1;
          end
          // pass is settled on entry to DONE so it is visible alongside done.
          if (idx == LAST) pass <= (err_cnt_nxt == '0);
          else             idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_apb_scoreboard.sv
// Directed bench for apb_scoreboard (DEPTH=8, DEVICE_ID=0): capture, compare, freeze, reset and mask cases.
module tb_apb_scoreboard;
  logic       clk = 1'b0;
  logic       rst, ready, apb_write, exp_load, start;
  logic [7:0] apb_addr, apb_data, exp_data, exp_mask;
  logic [3:0] apb_device, err_count;
  logic [2:0] exp_idx, first_err_idx;
  logic       busy, done, pass, err_valid;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] vals [8] = '{8'h1F, 8'h01, 8'h1E, 8'h01, 8'h01, 8'h1F, 8'h1F, 8'h00};

  apb_scoreboard #(.DATA_W(8), .ADDR_W(8), .DEV_W(4), .DEVICE_ID(0), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ready(ready), .apb_write(apb_write), .apb_addr(apb_addr),
    .apb_data(apb_data), .apb_device(apb_device), .exp_load(exp_load), .exp_idx(exp_idx),
    .exp_data(exp_data), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .err_valid(err_valid)
`ifdef APB_SCOREBOARD_MASK_EN
    , .exp_mask(exp_mask)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks (inputs change on negedge) ----------------
  task automatic idle_inputs();
    ready = 0; apb_write = 0; apb_addr = 0; apb_data = 0; apb_device = 0;
    exp_load = 0; exp_idx = 0; exp_data = 0; exp_mask = 8'hFF; start = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic apb_wr(input logic [7:0] addr, input logic [7:0] data, input logic [3:0] dev);
    @(negedge clk);
    ready = 1; apb_write = 1; apb_addr = addr; apb_data = data; apb_device = dev;
    @(negedge clk);
    ready = 0; apb_write = 0;
  endtask

  task automatic exp_ld(input logic [2:0] idx, input logic [7:0] data, input logic [7:0] mask);
    @(negedge clk);
    exp_load = 1; exp_idx = idx; exp_data = data; exp_mask = mask;
    @(negedge clk);
    exp_load = 0;
  endtask

  // Pulses start (along with any inputs already set by the caller) and observes the pass.
  // k counts negedges after the start edge; busy must be high for k=1..9 and low afterwards.
  task automatic run_pass(input bit inject, output int lat, output bit busy_ok, output logic p,
                          output logic [3:0] cnt, output logic [2:0] fe, output logic ev);
    lat = -1; busy_ok = 1; p = 'x; cnt = 'x; fe = 'x; ev = 'x;
    @(negedge clk); start = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 0; ready = 0; apb_write = 0; exp_load = 0; end
      if (inject && k == 2) begin
        ready = 1; apb_write = 1; apb_device = 0; apb_addr = 8'd7; apb_data = 8'h00;
        exp_load = 1; exp_idx = 3'd4; exp_data = 8'hAA;
      end
      if (inject && k == 3) begin ready = 0; apb_write = 0; exp_load = 0; start = 1; end
      if (inject && k == 4) start = 0;
      if (done) begin
        if (lat < 0) begin lat = k; p = pass; cnt = err_count; fe = first_err_idx; ev = err_valid; end
        else lat = 99;
      end
      if (k <= 9 && !busy) busy_ok = 0;
      if (k >= 10 && busy) busy_ok = 0;
    end
  endtask

  task automatic load_all_exp();
    for (int i = 0; i < 8; i++) exp_ld(3'(i), vals[i], 8'hFF);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({busy, done, pass, err_count, first_err_idx, err_valid} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b cnt=%0d fe=%0d ev=%b, want all 0",
               busy, done, pass, err_count, first_err_idx, err_valid);
    end
  endtask

  task automatic test_all_match();
    int lat; bit bok; logic p, ev; logic [3:0] cnt; logic [2:0] fe;
    load_all_exp();
    for (int i = 0; i < 8; i++) apb_wr(8'(i), vals[i], 4'd0);
    run_pass(0, lat, bok, p, cnt, fe, ev);
    tests_run++; if (lat !== 9) begin tests_failed++; $display("FAIL match_latency: got %0d want 9", lat); end
    tests_run++; if (bok !== 1'b1) begin tests_failed++; $display("FAIL match_busy_window: got %b want 1", bok); end
    tests_run++; if (p !== 1'b1) begin tests_failed++; $display("FAIL match_pass: got %b want 1", p); end
    tests_run++; if (cnt !== 4'd0) begin tests_failed++; $display("FAIL match_count: got %0d want 0", cnt); end
    tests_run++; if (ev !== 1'b0) begin tests_failed++; $display("FAIL match_err_valid: got %b want 0", ev); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL match_pass_held: got %b want 1", pass); end
  endtask

  task automatic test_mismatch();
    int lat; bit bok; logic p, ev; logic [3:0] cnt; logic [2:0] fe;
    apb_wr(8'd2, 8'h1F, 4'd0);
    apb_wr(8'd5, 8'h00, 4'd0);
    run_pass(0, lat, bok, p, cnt, fe, ev);
    tests_run++; if (p !== 1'b0) begin tests_failed++; $display("FAIL mism_pass: got %b want 0", p); end
    tests_run++; if (cnt !== 4'd2) begin tests_failed++; $display("FAIL mism_count: got %0d want 2", cnt); end
    tests_run++; if (fe !== 3'd2) begin tests_failed++; $display("FAIL mism_first_idx: got %0d want 2", fe); end
    tests_run++; if (ev !== 1'b1) begin tests_failed++; $display("FAIL mism_err_valid: got %b want 1", ev); end
  endtask

  task automatic test_missing_write();
    int lat; bit bok; logic p, ev; logic [3:0] cnt; logic [2:0] fe;
    do_reset();
    for (int i = 0; i < 7; i++) apb_wr(8'(i), vals[i], 4'd0);
    apb_wr(8'd7, 8'h00, 4'd3);  // wrong device: must not fill idx 7
    apb_wr(8'd3, 8'hEE, 4'd3);  // wrong device: must not corrupt idx 3
    apb_wr(8'd8, 8'hEE, 4'd0);  // out of range: would alias idx 0 if not rejected
    run_pass(0, lat, bok, p, cnt, fe, ev);
    tests_run++; if (cnt !== 4'd1) begin tests_failed++; $display("FAIL missing_count: got %0d want 1", cnt); end
    tests_run++; if (fe !== 3'd7) begin tests_failed++; $display("FAIL missing_first_idx: got %0d want 7", fe); end
    tests_run++; if (p !== 1'b0) begin tests_failed++; $display("FAIL missing_pass: got %b want 0", p); end
  endtask

  task automatic test_frozen();
    int lat; bit bok; logic p, ev; logic [3:0] cnt; logic [2:0] fe;
    run_pass(1, lat, bok, p, cnt, fe, ev);
    tests_run++; if (lat !== 9) begin tests_failed++; $display("FAIL frozen_latency: got %0d want 9", lat); end
    tests_run++; if (bok !== 1'b1) begin tests_failed++; $display("FAIL frozen_no_restart: got %b want 1", bok); end
    tests_run++; if (cnt !== 4'd1) begin tests_failed++; $display("FAIL frozen_count: got %0d want 1", cnt); end
    tests_run++; if (fe !== 3'd7) begin tests_failed++; $display("FAIL frozen_first_idx: got %0d want 7", fe); end
    run_pass(0, lat, bok, p, cnt, fe, ev);
    tests_run++; if (cnt !== 4'd1 || fe !== 3'd7) begin
      tests_failed++; $display("FAIL frozen_rerun: got cnt=%0d fe=%0d want cnt=1 fe=7", cnt, fe);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit bok; bit saw_done; logic p, ev; logic [3:0] cnt; logic [2:0] fe;
    saw_done = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); @(negedge clk); rst = 1;
    @(negedge clk);
    tests_run++;
    if ({busy, done, pass, err_count, first_err_idx, err_valid} !== 12'h000) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got busy=%b done=%b pass=%b cnt=%0d fe=%0d ev=%b, want all 0",
               busy, done, pass, err_count, first_err_idx, err_valid);
    end
    rst = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (done) saw_done = 1; end
    tests_run++; if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_done: got %b want 0", saw_done); end
    run_pass(0, lat, bok, p, cnt, fe, ev);
    tests_run++; if (cnt !== 4'd8) begin tests_failed++; $display("FAIL empty_count: got %0d want 8", cnt); end
    tests_run++; if (fe !== 3'd0 || ev !== 1'b1) begin
      tests_failed++; $display("FAIL empty_first_idx: got fe=%0d ev=%b want fe=0 ev=1", fe, ev);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok; logic p, ev; logic [3:0] cnt; logic [2:0] fe;
    exp_ld(3'd6, 8'h55, 8'hFF);
    for (int i = 0; i < 6; i++) apb_wr(8'(i), vals[i], 4'd0);
    apb_wr(8'd7, vals[7], 4'd0);
    // Same edge: expected load and capture on idx 6, then capture coincident with start.
    @(negedge clk);
    exp_load = 1; exp_idx = 3'd6; exp_data = 8'h1F; exp_mask = 8'hFF;
    ready = 1; apb_write = 1; apb_device = 0; apb_addr = 8'd6; apb_data = 8'h1F;
    @(negedge clk); exp_load = 0; ready = 0; apb_write = 0;
    apb_wr(8'd6, 8'h33, 4'd0);
    ready = 1; apb_write = 1; apb_device = 0; apb_addr = 8'd6; apb_data = 8'h1F;
    run_pass(0, lat, bok, p, cnt, fe, ev);
    tests_run++; if (p !== 1'b1 || cnt !== 4'd0) begin
      tests_failed++; $display("FAIL b2b_pass: got pass=%b cnt=%0d want pass=1 cnt=0", p, cnt);
    end
  endtask

`ifdef APB_SCOREBOARD_MASK_EN
  task automatic test_mask();
    int lat; bit bok; logic p, ev; logic [3:0] cnt; logic [2:0] fe;
    do_reset();
    load_all_exp();
    exp_ld(3'd1, 8'h01, 8'h0F);
    for (int i = 0; i < 8; i++) apb_wr(8'(i), (i == 1) ? 8'hF1 : vals[i], 4'd0);
    run_pass(0, lat, bok, p, cnt, fe, ev);
    tests_run++; if (p !== 1'b1 || cnt !== 4'd0) begin
      tests_failed++; $display("FAIL mask_hidden: got pass=%b cnt=%0d want pass=1 cnt=0", p, cnt);
    end
    exp_ld(3'd1, 8'h01, 8'hFF);
    run_pass(0, lat, bok, p, cnt, fe, ev);
    tests_run++; if (cnt !== 4'd1 || fe !== 3'd1) begin
      tests_failed++; $display("FAIL mask_full: got cnt=%0d fe=%0d want cnt=1 fe=1", cnt, fe);
    end
  endtask
`endif

  initial begin
    rst = 1; idle_inputs();
    test_reset();
    test_all_match();
    test_mismatch();
    test_missing_write();
    test_frozen();
    test_reset_mid();
    test_back_to_back();
`ifdef APB_SCOREBOARD_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
